// File: rtl/tryte_unpacker.sv
// Unpacks ASCII tryte characters into a packed block of balanced trits (2 bits per trit).
// Trytes fill the block from the low bits up; a block is emitted when full or when in_last arrives.
module tryte_unpacker #(
    parameter int TRYTES = 81
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [7:0]            in_tryte,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [6*TRYTES-1:0]   out_trits,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int CW = (TRYTES > 1) ? $clog2(TRYTES) : 1;

    logic [CW-1:0]         count_q, count_d;
    logic [6*TRYTES-1:0]   buf_q, buf_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  err_q, err_d;

    logic                  hs;
    logic                  legal;
    logic [4:0]            u;
    logic [4:0]            rem0, q1, rem1, q2;
    logic [5:0]            trits;

    // Base-3 digit d maps to trit d-1: 0 -> -1, 1 -> 0, 2 -> +1.
    function automatic logic [1:0] enc(input logic [1:0] d);
        case (d)
            2'd0:    enc = 2'b11;
            2'd2:    enc = 2'b01;
            default: enc = 2'b00;
        endcase
    endfunction

    assign in_ready  = !out_valid_q;
    assign hs        = in_valid && in_ready;
    assign out_trits = buf_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

    // u = v + 13 lies in 0..26; its base-3 digits minus one give the balanced trits.
    always_comb begin
        legal = 1'b1;
        u     = 5'd13;
        if (in_tryte == 8'h39) begin
            u = 5'd13;
        end else if (in_tryte >= 8'h41 && in_tryte <= 8'h4D) begin
            u = 5'(in_tryte - 8'h33);
        end else if (in_tryte >= 8'h4E && in_tryte <= 8'h5A) begin
            u = 5'(in_tryte - 8'h4E);
        end else begin
            legal = 1'b0;
        end
        rem0  = u % 5'd3;
        q1    = u / 5'd3;
        rem1  = q1 % 5'd3;
        q2    = q1 / 5'd3;
        trits = legal ? {enc(q2[1:0]), enc(rem1[1:0]), enc(rem0[1:0])} : 6'd0;
    end

    always_comb begin
        count_d     = count_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        if (clear) begin
            count_d     = '0;
            buf_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            err_d       = 1'b0;
        end else if (out_valid_q) begin
            if (out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                buf_d       = '0;
            end
        end else if (hs) begin
            for (int i = 0; i < TRYTES; i++) begin
                if (count_q == CW'(i)) begin
                    buf_d[6*i +: 6] = trits;
                end
            end
            if (!legal) begin
                err_d = 1'b1;
            end
            if (in_last || count_q == CW'(TRYTES - 1)) begin
                count_d     = '0;
                out_valid_d = 1'b1;
                out_last_d  = in_last;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_tryte_unpacker.sv
// Directed bench for tryte_unpacker: single-tryte vector table plus multi-cycle block sequences.
module tb_tryte_unpacker;

    localparam int TRYTES = 81;
    localparam int W = 6 * TRYTES;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic [7:0]    in_tryte;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [W-1:0]  out_trits;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          err;

    int errors = 0;
    int checks = 0;
    int blk_cnt = 0;

    tryte_unpacker #(.TRYTES(TRYTES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_tryte  (in_tryte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_trits (out_trits),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) blk_cnt <= blk_cnt + 1;
    end

    typedef struct {
        logic [7:0] ch;
        logic [5:0] trits;
        logic       illegal;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_tryte = c;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [W-1:0] snap;
        logic [W-1:0] exp_blk;
        int           base;
        logic         stable;

        vecs[0]  = '{8'h39, 6'b000000, 1'b0};  // '9' = 0
        vecs[1]  = '{8'h41, 6'b000001, 1'b0};  // 'A' = +1
        vecs[2]  = '{8'h42, 6'b000111, 1'b0};  // 'B' = +2 = -1 + 3
        vecs[3]  = '{8'h44, 6'b000101, 1'b0};  // 'D' = +4 = 1 + 3
        vecs[4]  = '{8'h45, 6'b011111, 1'b0};  // 'E' = +5 = -1 - 3 + 9
        vecs[5]  = '{8'h4D, 6'b010101, 1'b0};  // 'M' = +13
        vecs[6]  = '{8'h4E, 6'b111111, 1'b0};  // 'N' = -13
        vecs[7]  = '{8'h52, 6'b110000, 1'b0};  // 'R' = -9
        vecs[8]  = '{8'h5A, 6'b000011, 1'b0};  // 'Z' = -1
        vecs[9]  = '{8'h61, 6'b000000, 1'b1};  // 'a' illegal
        vecs[10] = '{8'h40, 6'b000000, 1'b1};  // '@' just below 'A'
        vecs[11] = '{8'h5B, 6'b000000, 1'b1};  // '[' just above 'Z'

        reset_n = 1'b0; clear = 1'b0; in_tryte = 8'h00; in_valid = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_trits_zero", {63'd0, out_trits == '0}, 64'd1);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Table: each character as a one-tryte message.
        for (int i = 0; i < 12; i++) begin
            do_clear();
            send(vecs[i].ch, 1'b1);
            chk("vec_valid", {63'd0, out_valid}, 64'd1);
            chk("vec_slot0", {58'd0, out_trits[5:0]}, {58'd0, vecs[i].trits});
            chk("vec_rest_zero", {63'd0, out_trits[W-1:6] == '0}, 64'd1);
            chk("vec_last", {63'd0, out_last}, 64'd1);
            chk("vec_err", {63'd0, err}, {63'd0, vecs[i].illegal});
            $display("vec %0d char %02h slot0 %b err %b", i, vecs[i].ch, out_trits[5:0], err);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("vec_drop", {63'd0, out_valid}, 64'd0);
        end

        // 81 x '9' back to back, downstream always ready.
        do_clear();
        out_ready = 1'b1;
        in_valid = 1'b1; in_tryte = 8'h39; in_last = 1'b0;
        for (int i = 0; i < TRYTES; i++) begin
            tick();
            if (i == TRYTES - 2) chk("full_no_early", {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b0;
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        chk("full_zero", {63'd0, out_trits == '0}, 64'd1);
        chk("full_last", {63'd0, out_last}, 64'd0);
        chk("full_in_ready_low", {63'd0, in_ready}, 64'd0);
        tick();
        chk("full_drop", {63'd0, out_valid}, 64'd0);
        chk("full_in_ready_back", {63'd0, in_ready}, 64'd1);
        $display("full block of 81 '9' emitted");

        // "AMNZ" with in_last on 'Z', downstream stalled.
        out_ready = 1'b0;
        send(8'h41, 1'b0); send(8'h4D, 1'b0); send(8'h4E, 1'b0); send(8'h5A, 1'b1);
        chk("amnz_slots", {40'd0, out_trits[23:0]}, {40'd0, 24'b000011_111111_010101_000001});
        chk("amnz_rest", {63'd0, out_trits[W-1:24] == '0}, 64'd1);
        chk("amnz_last", {63'd0, out_last}, 64'd1);
        $display("AMNZ slots %h", out_trits[23:0]);

        // Stall 10 cycles with input offered: block must hold, nothing accepted.
        snap = out_trits;
        stable = 1'b1;
        in_valid = 1'b1; in_tryte = 8'h41; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_trits !== snap || out_valid !== 1'b1 || in_ready !== 1'b0 || out_last !== 1'b1)
                stable = 1'b0;
        end
        chk("stall_stable", {63'd0, stable}, 64'd1);
        base = blk_cnt;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release_drop", {63'd0, out_valid}, 64'd0);
        tick(); tick();
        chk("stall_one_transfer", 64'(blk_cnt - base), 64'd1);
        send(8'h5A, 1'b1);
        chk("stall_no_stray", {52'd0, out_trits[11:0]}, {52'd0, 12'b000000_000011});
        tick();

        // Illegal character mid-block; err is sticky across blocks.
        do_clear();
        send(8'h41, 1'b0); send(8'h61, 1'b0); send(8'h4D, 1'b0); send(8'h42, 1'b1);
        chk("ill_slots", {40'd0, out_trits[23:0]}, {40'd0, 24'b000111_010101_000000_000001});
        chk("ill_err", {63'd0, err}, 64'd1);
        tick();
        send(8'h44, 1'b1);
        chk("ill_err_sticky", {63'd0, err}, 64'd1);
        chk("ill_next_slot", {58'd0, out_trits[5:0]}, {58'd0, 6'b000101});
        tick();
        do_clear();
        chk("ill_err_cleared", {63'd0, err}, 64'd0);

        // Reset after 40 trytes, then 81 'D': one block of only 'D'.
        for (int i = 0; i < 40; i++) send(8'h41, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_trits_zero", {63'd0, out_trits == '0}, 64'd1);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        reset_n = 1'b1;
        tick();
        base = blk_cnt;
        exp_blk = '0;
        for (int i = 0; i < TRYTES; i++) begin
            exp_blk[6*i +: 6] = 6'b000101;
            send(8'h44, 1'b0);
        end
        chk("midrst_block", {63'd0, out_trits == exp_blk}, 64'd1);
        chk("midrst_valid", {63'd0, out_valid}, 64'd1);
        tick(); tick();
        chk("midrst_one_block", 64'(blk_cnt - base), 64'd1);

        // in_last on the 81st tryte: one block with out_last, nothing after.
        base = blk_cnt;
        for (int i = 0; i < TRYTES - 1; i++) send(8'h39, 1'b0);
        send(8'h39, 1'b1);
        chk("lastfull_last", {63'd0, out_last}, 64'd1);
        tick(); tick(); tick();
        chk("lastfull_one_block", 64'(blk_cnt - base), 64'd1);

        // clear on the 81st handshake; stray in_last/in_tryte with in_valid low.
        base = blk_cnt;
        for (int i = 0; i < TRYTES - 1; i++) send(8'h41, 1'b0);
        clear = 1'b1;
        send(8'h41, 1'b0);
        clear = 1'b0;
        chk("clr_no_valid", {63'd0, out_valid}, 64'd0);
        in_tryte = 8'h4D; in_last = 1'b1;
        tick(); tick(); tick();
        in_last = 1'b0;
        chk("clr_no_block", 64'(blk_cnt - base), 64'd0);
        send(8'h41, 1'b1);
        chk("clr_counter_zero", {52'd0, out_trits[11:0]}, {52'd0, 12'b000000_000001});
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tryte_unpacker.md
TRYTE_UNPACKER -- requirements
Module: tryte_unpacker

Interface
REQ-001 The block SHALL have a parameter TRYTES, default 81, giving the number of trytes per output block (243 trits, one curl absorb chunk).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have a port clear, input, 1 bit: synchronous soft clear, discards the partial block and the error flag.
REQ-005 The block SHALL have a port in_tryte, input, 8 bits: ASCII tryte character.
REQ-006 The block SHALL have a port in_valid, input, 1 bit: in_tryte is valid.
REQ-007 The block SHALL have a port in_last, input, 1 bit: the current tryte ends the message.
REQ-008 The block SHALL have a port in_ready, output, 1 bit: the block accepts a tryte this cycle.
REQ-009 The block SHALL have a port out_trits, output, 6*TRYTES bits: packed trit block, 2 bits per trit.
REQ-010 The block SHALL have a port out_valid, output, 1 bit: out_trits holds a complete block.
REQ-011 The block SHALL have a port out_last, output, 1 bit: the block contains the final tryte of a message.
REQ-012 The block SHALL have a port out_ready, input, 1 bit: downstream (converter/curl) accepts the block.
REQ-013 The block SHALL have a port err, output, 1 bit: sticky, set by an illegal character.

Function
REQ-014 Trit encoding SHALL be 2'b00 = 0, 2'b01 = +1, 2'b11 = -1; 2'b10 is never produced.
REQ-015 Character mapping SHALL be '9' (0x39) -> 0; 'A'..'M' (0x41..0x4D) -> +1..+13; 'N'..'Z' (0x4E..0x5A) -> -13..-1.
REQ-016 Each tryte value v SHALL expand to balanced trits t0 + 3*t1 + 9*t2 = v, with t0 in the lowest 2 bits.
REQ-017 Tryte k (0-based arrival order) SHALL occupy out_trits[6k+5:6k]; earlier trytes go to lower bits.
REQ-018 An illegal character (any other code) SHALL be accepted, stored as three zero trits, and set err; err stays set until clear or reset.
REQ-019 A handshake SHALL occur on in_valid && in_ready; in_ready SHALL equal !out_valid.
REQ-020 The block SHALL keep a tryte counter, 0..TRYTES-1, incremented on each handshake.
REQ-021 On a handshake with counter = TRYTES-1, or with in_last = 1, the counter SHALL reset to 0 and out_valid SHALL go 1 in the next cycle.
REQ-022 When in_last ends a partial block, unfilled tryte positions SHALL be zero trits and out_last SHALL be 1.
REQ-023 When in_last coincides with counter = TRYTES-1, the block SHALL be emitted once with out_last = 1; no empty block follows.
REQ-024 out_trits and out_last SHALL be held stable while out_valid = 1 && out_ready = 0.
REQ-025 On out_valid && out_ready, out_valid SHALL drop next cycle; the block buffer SHALL be zeroed; in_ready rises in the same cycle.
REQ-026 Throughput SHALL be one tryte per cycle while filling, plus one bubble cycle per block.
REQ-027 clear SHALL take priority over any handshake in the same cycle: counter = 0, buffer zeroed, out_valid = 0, out_last = 0, err = 0.
REQ-028 in_tryte and in_last SHALL be ignored when in_valid = 0.

Reset
REQ-029 While reset_n = 0, the block SHALL force out_valid = 0, out_last = 0, err = 0, out_trits = 0, and counter = 0.
REQ-030 As a result, in_ready SHALL be 1 during reset and immediately after it.
REQ-031 Reset asserted mid-block SHALL discard the partial block; no output SHALL be emitted for it.

Verification
REQ-032 With TRYTES = 81, feed 81 × '9' back-to-back with out_ready = 1: out_valid rises exactly one cycle after the 81st handshake, out_trits = 0, out_last = 0, in_ready is low for 1 cycle.
REQ-033 Feed "AMNZ" with in_last on 'Z': tryte 0 = {00,00,01}, tryte 1 ('M' = +13) = {01,01,01}, tryte 2 ('N' = -13) = {11,11,11}, tryte 3 = {00,00,11}; remaining trytes are 0; out_last = 1.
REQ-034 Hold out_ready = 0 for 10 cycles with a full block: out_trits is stable, in_ready = 0, and no input is accepted; on release, the block is transferred once.
REQ-035 Send 'a' (0x61) mid-block: its slot is zero, err = 1 and stays 1 across later blocks; clear returns err to 0.
REQ-036 Pulse reset_n low after 40 trytes, then feed 81 trytes: exactly one block is emitted, and it contains only the post-reset trytes.
REQ-037 Assert clear in the same cycle as the 81st handshake: no block is emitted and the counter is 0.
